// File: rtl/display_ctrl.sv
// Binary-to-BCD front end for a 3-digit multiplexed 7-segment display.
// Converts with a serial double-dabble engine and publishes {bcd, blank, ovf} atomically.
module display_ctrl #(
   parameter int BIN_W    = 10,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [11:0]      bcd,
   output logic             bcd_valid,
   output logic [2:0]       blank,
   output logic             ovf,
   output logic             scan_tick
);

   localparam int                CNT_W   = $clog2(BIN_W);
   localparam int                DIV_W   = $clog2(SCAN_DIV);
   localparam logic [BIN_W-1:0]  DIN_MAX = BIN_W'(999);
   localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(BIN_W - 1);
   localparam logic [DIV_W-1:0]  DIV_TOP = DIV_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [11:0]      work_q, work_d;
   logic [BIN_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovfn_q, ovfn_d;
   logic [11:0]      bcd_q, bcd_d;
   logic [2:0]       blank_q, blank_d;
   logic             ovf_q, ovf_d;
   logic             bcd_valid_q, bcd_valid_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;

   logic [11:0]      adj;
   logic             unused_adj_msb;

   // Add-3 correction per nibble; a nibble >= 5 tops out at 12, so no carry.
   always_comb begin
      adj = work_q;
      for (int i = 0; i < 3; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

   // Values are capped at 999, so the bit shifted out of the hundreds nibble is always 0.
   assign unused_adj_msb = adj[11];

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      ovfn_d      = ovfn_q;
      bcd_d       = bcd_q;
      blank_d     = blank_q;
      ovf_d       = ovf_q;
      bcd_valid_d = 1'b0;
      din_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               if (din > DIN_MAX) begin
                  work_d  = 12'h999;
                  ovfn_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  shreg_d = din;
                  work_d  = 12'h000;
                  cnt_d   = '0;
                  ovfn_d  = 1'b0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d  = {adj[10:0], shreg_q[BIN_W-1]};
            shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT)
               state_d = DONE;
         end
         DONE: begin
            bcd_d       = work_q;
            ovf_d       = ovfn_q;
            blank_d[2]  = (work_q[11:8] == 4'd0);
            blank_d[1]  = (work_q[11:8] == 4'd0) && (work_q[7:4] == 4'd0);
            blank_d[0]  = 1'b0;
            bcd_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan divider runs freely; the tick is registered so it is glitch-free.
   always_comb begin
      div_d  = div_q + DIV_W'(1);
      tick_d = 1'b0;
      if (div_q == DIV_TOP) begin
         div_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= 12'h000;
         shreg_q     <= '0;
         cnt_q       <= '0;
         ovfn_q      <= 1'b0;
         bcd_q       <= 12'h000;
         blank_q     <= 3'b110;
         ovf_q       <= 1'b0;
         bcd_valid_q <= 1'b0;
         div_q       <= '0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         ovfn_q      <= ovfn_d;
         bcd_q       <= bcd_d;
         blank_q     <= blank_d;
         ovf_q       <= ovf_d;
         bcd_valid_q <= bcd_valid_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
      end
   end

   assign bcd       = bcd_q;
   assign blank     = blank_q;
   assign ovf       = ovf_q;
   assign bcd_valid = bcd_valid_q;
   assign scan_tick = tick_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: accepts push decimal-rule expectations, a monitor pops on bcd_valid.
module tb_display_ctrl;
   localparam int BIN_W    = 10;
   localparam int SCAN_DIV = 4;
   localparam int LAT      = BIN_W + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [BIN_W-1:0] din = '0;
   logic             din_valid = 1'b0;
   logic             din_ready, bcd_valid, ovf, scan_tick;
   logic [11:0]      bcd;
   logic [2:0]       blank;

   display_ctrl #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .bcd(bcd), .bcd_valid(bcd_valid), .blank(blank), .ovf(ovf), .scan_tick(scan_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] bcd;
      logic [2:0]  blank;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          errors = 0, checks = 0;
   int          cyc = 0, rcyc = 0, pulses = 0;
   logic [11:0] last_bcd = 12'h000;
   logic [2:0]  last_blank = 3'b110;
   logic        last_ovf = 1'b0;

   function automatic exp_t model(int v, int now);
      exp_t e;
      int   s;
      s         = (v > 999) ? 999 : v;
      e.bcd     = {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
      e.blank   = {s < 100, s < 10, 1'b0};
      e.ovf     = (v > 999);
      e.due     = now + ((v > 999) ? 1 : LAT);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Accept observer and cycle counters.
   always @(posedge clk) begin
      cyc++;
      if (reset) rcyc = 0;
      else rcyc++;
      if (!reset && din_valid && din_ready)
         q.push_back(model(int'(din), cyc));
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q.delete();
         last_bcd   = 12'h000;
         last_blank = 3'b110;
         last_ovf   = 1'b0;
         chk("rst_bcd", bcd, 12'h000);
         chk("rst_blank", blank, 3'b110);
         chk("rst_ovf", ovf, 0);
         chk("rst_bcd_valid", bcd_valid, 0);
         chk("rst_scan_tick", scan_tick, 0);
         chk("rst_din_ready", din_ready, 1);
      end else begin
         chk("din_ready", din_ready, (q.size() == 0 || bcd_valid) ? 1 : 0);
         if (bcd_valid) begin
            pulses++;
            if (q.size() == 0) begin
               chk("unexpected_bcd_valid", bcd_valid, 0);
            end else begin
               e = q.pop_front();
               chk("bcd", bcd, e.bcd);
               chk("blank", blank, e.blank);
               chk("ovf", ovf, e.ovf);
               chk("latency", cyc, e.due);
               last_bcd   = e.bcd;
               last_blank = e.blank;
               last_ovf   = e.ovf;
            end
         end else begin
            chk("hold_bcd", bcd, last_bcd);
            chk("hold_blank", blank, last_blank);
            chk("hold_ovf", ovf, last_ovf);
         end
         chk("scan_tick", scan_tick, (rcyc > 0 && rcyc % SCAN_DIV == 0) ? 1 : 0);
      end
   end

   // Present v until accepted; while the DUT is busy, din carries junk that must be ignored.
   task automatic send(input int v, input bit keep);
      bit ok = 1'b0;
      din_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (din_ready && !reset) begin
            din = BIN_W'(v);
            ok  = 1'b1;
            break;
         end
         din = BIN_W'($urandom);
         @(negedge clk);
      end
      chk("accept_timeout", ok, 1);
      if (ok) @(negedge clk);
      if (!keep) din_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("drain", q.size(), 0);
   endtask

   initial begin
      int p0, v;
      bit keep;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Directed values, including blanking and overflow boundaries.
      send(0, 0);    drain();
      send(345, 0);  drain();
      send(42, 0);   drain();
      send(7, 0);    drain();
      send(999, 0);  drain();
      send(1000, 0); drain();
      send(1023, 0); drain();
      send(5, 0);    drain();

      // Back-to-back with valid held high and junk on din while busy.
      p0 = pulses;
      send(123, 1);
      send(456, 1);
      send(789, 0);
      drain();
      chk("b2b_pulses", pulses - p0, 3);

      // Reset in SHIFT cycle 5 of a conversion: nothing may be published.
      p0 = pulses;
      send(678, 0);
      repeat (4) @(negedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      chk("reset_no_pulse", pulses - p0, 0);
      chk("reset_bcd", bcd, 12'h000);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 1023));
            1: v = int'($urandom_range(0, 9));
            2: v = int'($urandom_range(995, 1005));
            default: v = int'($urandom_range(0, 999));
         endcase
         keep = 1'($urandom_range(0, 1));
         send(v, keep);
         if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      din_valid = 1'b0;
      drain();
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
